alu_issue_stage: RTL and testbench

- Producer side of the ALU operation interface: decodes ALU-class RV32I instructions into an ALU opcode, two 32-bit operands, and writeback control.
- Registered, with a valid/ready handshake on both sides.
- Sits between register-file read and the execute stage.
- Its outputs drive the ALU's op/op_1/op_2 inputs directly, so downstream sees only fully formed operands.

---
 rtl/alu_issue_pkg.sv | 61 ++++++
 rtl/alu_issue_decode.sv | 121 ++++++++++++
 rtl/alu_issue_stage.sv | 141 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
package alu_issue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 8;
    localparam int unsigned REGW = 5;

    // ALU opcode encoding; ALU_SLTU appended after the existing values.
    localparam logic [OPW-1:0] ALU_ADD  = 8'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 8'd1;
    localparam logic [OPW-1:0] ALU_SLL  = 8'd2;
    localparam logic [OPW-1:0] ALU_SLT  = 8'd3;
    localparam logic [OPW-1:0] ALU_XOR  = 8'd4;
    localparam logic [OPW-1:0] ALU_SRL  = 8'd5;
    localparam logic [OPW-1:0] ALU_SRA  = 8'd6;
    localparam logic [OPW-1:0] ALU_OR   = 8'd7;
    localparam logic [OPW-1:0] ALU_AND  = 8'd8;
    localparam logic [OPW-1:0] ALU_SLTU = 8'd9;

    // RV32I major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded ALU micro-op as presented to the execute stage.
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] op_1;
        logic [XLEN-1:0] op_2;
        logic [REGW-1:0] rd;
        logic            rd_we;
        logic            illegal;
    } alu_uop_t;

    // One buffered entry: micro-op plus the PC it came from.
    typedef struct packed {
        alu_uop_t        uop;
        logic [XLEN-1:0] pc;
    } issue_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_e;

    // Sign-extended I-type immediate.
    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    // U-type immediate, upper 20 bits placed above 12 zeros.
    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of ALU-class RV32I instructions into a micro-op.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output alu_uop_t        uop_c
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] shamt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign shamt  = {27'b0, instr[24:20]};

    logic            legal;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] op_1;
    logic [XLEN-1:0] op_2;

    // Opcode/funct decode; anything unrecognised collapses to a zeroed ADD.
    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        op_1  = '0;
        op_2  = '0;
        unique case (opcode)
            OPC_OP: begin
                op_1 = rs1_val;
                op_2 = rs2_val;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'd0:    op = ALU_ADD;
                        3'd1:    op = ALU_SLL;
                        3'd2:    op = ALU_SLT;
                        3'd3:    op = ALU_SLTU;
                        3'd4:    op = ALU_XOR;
                        3'd5:    op = ALU_SRL;
                        3'd6:    op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd0) begin
                        legal = 1'b1;
                        op    = ALU_SUB;
                    end else if (funct3 == 3'd5) begin
                        legal = 1'b1;
                        op    = ALU_SRA;
                    end
                end
            end
            OPC_OP_IMM: begin
                op_1  = rs1_val;
                op_2  = imm_i(instr);
                legal = 1'b1;
                case (funct3)
                    3'd0: op = ALU_ADD;
                    3'd2: op = ALU_SLT;
                    3'd3: op = ALU_SLTU;
                    3'd4: op = ALU_XOR;
                    3'd6: op = ALU_OR;
                    3'd7: op = ALU_AND;
                    3'd1: begin
                        // ALU shifts by all of op_2, so only the 5-bit shamt may pass.
                        op    = ALU_SLL;
                        op_2  = shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        op_2 = shamt;
                        if (funct7 == F7_BASE) begin
                            op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                op_1  = '0;
                op_2  = imm_u(instr);
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op_1  = pc;
                op_2  = imm_u(instr);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            op   = ALU_ADD;
            op_1 = '0;
            op_2 = '0;
        end
    end

    // Assemble micro-op; x0 and illegal encodings never write back.
    always_comb begin
        uop_c.op      = op;
        uop_c.op_1    = op_1;
        uop_c.op_2    = op_2;
        uop_c.rd      = rd;
        uop_c.rd_we   = legal && (rd != 5'd0);
        uop_c.illegal = !legal;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a two-entry skid buffer with registered ready.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OPW-1:0]  o_alu_op,
    output logic [XLEN-1:0] o_op_1,
    output logic [XLEN-1:0] o_op_2,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_pc
);

    alu_uop_t     in_uop_c;
    issue_entry_t in_entry_c;

    alu_issue_decode u_decode (
        .instr   (i_instr),
        .pc      (i_pc),
        .rs1_val (i_rs1_val),
        .rs2_val (i_rs2_val),
        .uop_c   (in_uop_c)
    );

    assign in_entry_c.uop = in_uop_c;
    assign in_entry_c.pc  = i_pc;

    issue_state_e state_q;
    issue_state_e state_d;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_valid_q;
    logic         ready_q;

    logic accept_c;
    logic drain_c;
    logic load_main_in_c;
    logic load_main_skid_c;
    logic load_skid_c;

    assign accept_c = i_valid && ready_q;
    assign drain_c  = main_valid_q && i_ready;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and buffer steering; flush overrides accept and drain.
    always_comb begin
        state_d          = state_q;
        load_main_in_c   = 1'b0;
        load_main_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d        = ST_BUSY;
                        load_main_in_c = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept_c && drain_c) begin
                        load_main_in_c = 1'b1;
                    end else if (accept_c) begin
                        state_d     = ST_FULL;
                        load_skid_c = 1'b1;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain_c) begin
                        state_d          = ST_BUSY;
                        load_main_skid_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake flags derived from the next state so both are plain flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_valid_q <= (state_d != ST_EMPTY);
            ready_q      <= (state_d != ST_FULL);
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in_c) begin
                main_q <= in_entry_c;
            end else if (load_main_skid_c) begin
                main_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= in_entry_c;
            end
        end
    end

    assign o_valid   = main_valid_q;
    assign o_ready   = ready_q;
    assign o_alu_op  = main_q.uop.op;
    assign o_op_1    = main_q.uop.op_1;
    assign o_op_2    = main_q.uop.op_2;
    assign o_rd      = main_q.uop.rd;
    assign o_rd_we   = main_q.uop.rd_we;
    assign o_illegal = main_q.uop.illegal;
    assign o_pc      = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table plus handshake corner cases.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_val;
    logic [31:0] i_rs2_val;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_alu_op;
    logic [31:0] o_op_1;
    logic [31:0] o_op_2;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic        o_illegal;
    logic [31:0] o_pc;

    alu_issue_stage dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_instr   (i_instr),
        .i_pc      (i_pc),
        .i_rs1_val (i_rs1_val),
        .i_rs2_val (i_rs2_val),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_alu_op  (o_alu_op),
        .o_op_1    (o_op_1),
        .o_op_2    (o_op_2),
        .o_rd      (o_rd),
        .o_rd_we   (o_rd_we),
        .o_illegal (o_illegal),
        .o_pc      (o_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [7:0]  op;
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    int checks;
    int errors;

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [7:0] op,
                                input logic [31:0] op_1, input logic [31:0] op_2, input logic [4:0] rd,
                                input logic rd_we, input logic illegal);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.op = op; v.op_1 = op_1; v.op_2 = op_2; v.rd = rd; v.rd_we = rd_we; v.illegal = illegal;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_valid   = 1'b1;
        i_instr   = v.instr;
        i_pc      = v.pc;
        i_rs1_val = v.rs1;
        i_rs2_val = v.rs2;
    endtask

    task automatic check_out(input vec_t v);
        chk({v.name, ".valid"},   32'(o_valid),   32'd1);
        chk({v.name, ".op"},      32'(o_alu_op),  32'(v.op));
        chk({v.name, ".op_1"},    o_op_1,         v.op_1);
        chk({v.name, ".op_2"},    o_op_2,         v.op_2);
        chk({v.name, ".rd"},      32'(o_rd),      32'(v.rd));
        chk({v.name, ".rd_we"},   32'(o_rd_we),   32'(v.rd_we));
        chk({v.name, ".illegal"}, 32'(o_illegal), 32'(v.illegal));
        chk({v.name, ".pc"},      o_pc,           v.pc);
    endtask

    vec_t add_v, a_m1, a_2, a_3;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = mk("add",      32'h002081B3, 32'h0000_0040, 32'd5,        32'd7,  ALU_ADD,  32'd5,        32'd7,        5'd3,  1'b1, 1'b0);
        vecs[1]  = mk("sub",      32'h407302B3, 32'h0000_0044, 32'd10,       32'd3,  ALU_SUB,  32'd10,       32'd3,        5'd5,  1'b1, 1'b0);
        vecs[2]  = mk("sltu",     32'h003130B3, 32'h0000_0048, 32'h1,        32'h2,  ALU_SLTU, 32'h1,        32'h2,        5'd1,  1'b1, 1'b0);
        vecs[3]  = mk("sra",      32'h4041D133, 32'h0000_004C, 32'hF000_0000,32'd4,  ALU_SRA,  32'hF000_0000,32'd4,        5'd2,  1'b1, 1'b0);
        vecs[4]  = mk("or",       32'h0020E333, 32'h0000_0050, 32'h0F0,      32'h00F,ALU_OR,   32'h0F0,      32'h00F,      5'd6,  1'b1, 1'b0);
        vecs[5]  = mk("op_bad",   32'h402091B3, 32'h0000_0054, 32'd9,        32'd9,  ALU_ADD,  32'd0,        32'd0,        5'd3,  1'b0, 1'b1);
        vecs[6]  = mk("add_x0",   32'h00208033, 32'h0000_0058, 32'd1,        32'd2,  ALU_ADD,  32'd1,        32'd2,        5'd0,  1'b0, 1'b0);
        vecs[7]  = mk("srai",     32'h41F0D213, 32'h0000_005C, 32'h8000_0000,32'd0,  ALU_SRA,  32'h8000_0000,32'h0000_001F,5'd4,  1'b1, 1'b0);
        vecs[8]  = mk("srai_bad", 32'h03F0D213, 32'h0000_0060, 32'h8000_0000,32'd0,  ALU_ADD,  32'd0,        32'd0,        5'd4,  1'b0, 1'b1);
        vecs[9]  = mk("addi_m1",  32'hFFF08393, 32'h0000_0064, 32'd100,      32'd0,  ALU_ADD,  32'd100,      32'hFFFF_FFFF,5'd7,  1'b1, 1'b0);
        vecs[10] = mk("sltiu",    32'h8004B413, 32'h0000_0068, 32'd3,        32'd0,  ALU_SLTU, 32'd3,        32'hFFFF_F800,5'd8,  1'b1, 1'b0);
        vecs[11] = mk("slli",     32'h00311093, 32'h0000_006C, 32'd6,        32'd0,  ALU_SLL,  32'd6,        32'd3,        5'd1,  1'b1, 1'b0);
        vecs[12] = mk("andi",     32'h7FF17113, 32'h0000_0070, 32'h1234,     32'd0,  ALU_AND,  32'h1234,     32'h0000_07FF,5'd2,  1'b1, 1'b0);
        vecs[13] = mk("auipc",    32'h12345297, 32'h0000_0100, 32'hDEAD,     32'd0,  ALU_ADD,  32'h0000_0100,32'h1234_5000,5'd5,  1'b1, 1'b0);
        vecs[14] = mk("lui_x0",   32'hABCDE037, 32'h0000_0104, 32'h5555,     32'd0,  ALU_ADD,  32'd0,        32'hABCD_E000,5'd0,  1'b0, 1'b0);
        vecs[15] = mk("jal",      32'h000000EF, 32'h0000_0108, 32'd1,        32'd1,  ALU_ADD,  32'd0,        32'd0,        5'd1,  1'b0, 1'b1);

        add_v = vecs[0];
        a_m1  = mk("bp_m1", 32'hFFF00093, 32'h200, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
        a_2   = mk("bp_2",  32'h00200093, 32'h204, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd2,         5'd1, 1'b1, 1'b0);
        a_3   = mk("bp_3",  32'h00300093, 32'h208, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd3,         5'd1, 1'b1, 1'b0);

        // Reset state.
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_instr = 32'h0; i_pc = 32'h0; i_rs1_val = 32'h0; i_rs2_val = 32'h0;
        #1;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.op_2",  o_op_2,       32'd0);
        chk("rst.pc",    o_pc,         32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Decode table, streamed back-to-back with downstream always ready.
        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k]);
            @(negedge i_clk);
            check_out(vecs[k]);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("drain.valid", 32'(o_valid), 32'd0);

        // Backpressure: two accepts fill the buffer, third waits.
        i_ready = 1'b0;
        drive(a_m1);
        @(negedge i_clk);
        chk("bp.ready_busy", 32'(o_ready), 32'd1);
        drive(a_2);
        @(negedge i_clk);
        chk("bp.ready_full", 32'(o_ready), 32'd0);
        check_out(a_m1);
        drive(a_3);
        @(negedge i_clk);
        check_out(a_m1);
        chk("bp.ready_hold", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        @(negedge i_clk);
        check_out(a_2);
        chk("bp.ready_back", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        check_out(a_3);
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("bp.empty", 32'(o_valid), 32'd0);

        // Flush from FULL with a concurrent valid input.
        i_ready = 1'b0;
        drive(a_m1);
        @(negedge i_clk);
        drive(a_2);
        @(negedge i_clk);
        chk("fl.full_ready", 32'(o_ready), 32'd0);
        drive(a_3);
        i_flush = 1'b1;
        @(negedge i_clk);
        chk("fl.valid", 32'(o_valid), 32'd0);
        chk("fl.ready", 32'(o_ready), 32'd1);
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("fl.no_ghost", 32'(o_valid), 32'd0);
        end

        // Flush from BUSY drops the same-cycle accept.
        i_ready = 1'b0;
        drive(a_m1);
        @(negedge i_clk);
        drive(a_2);
        i_flush = 1'b1;
        @(negedge i_clk);
        chk("flb.valid", 32'(o_valid), 32'd0);
        chk("flb.ready", 32'(o_ready), 32'd1);
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(negedge i_clk);
        chk("flb.no_ghost", 32'(o_valid), 32'd0);

        // Asynchronous reset while BUSY, then normal issue.
        i_ready = 1'b0;
        drive(add_v);
        @(negedge i_clk);
        check_out(add_v);
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst.valid", 32'(o_valid), 32'd0);
        chk("arst.ready", 32'(o_ready), 32'd1);
        chk("arst.op_1",  o_op_1,       32'd0);
        chk("arst.rd",    32'(o_rd),    32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        drive(add_v);
        @(negedge i_clk);
        check_out(add_v);
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("arst.drain", 32'(o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
